// File: rtl/pet_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pet_video_pkg
// Description : Shared widths, cell geometry and vertical phase encoding
//               for the PET text-mode CRTC.
// Revision    : 1.0 - initial release
// ============================================================================
package pet_video_pkg;

    localparam int H_W          = 8;
    localparam int V_W          = 7;
    localparam int RA_W         = 5;
    localparam int ADDR_W       = 12;
    localparam int PIX_PER_CHAR = 8;
    localparam int PIX_W        = 3;

    typedef enum logic [0:0] {
        PH_DISPLAY = 1'b0,
        PH_ADJUST  = 1'b1
    } vphase_t;

endpackage
`default_nettype wire

// File: rtl/crtc_timing.sv
`default_nettype none
// ============================================================================
// Module      : crtc_timing
// Description : Pixel/character/scanline/row counters, sync and display
//               windows, and the refresh memory address.
// Revision    : 1.0 - initial release
// ============================================================================
module crtc_timing
    import pet_video_pkg::*;
(
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic [H_W-1:0]    h_char_total,
    input  logic [H_W-1:0]    h_char_displayed,
    input  logic [H_W-1:0]    h_sync_pos,
    input  logic [3:0]        h_sync_width,
    input  logic [RA_W-1:0]   v_char_height,
    input  logic [V_W-1:0]    v_char_total,
    input  logic [V_W-1:0]    v_char_displayed,
    input  logic [V_W-1:0]    v_sync_pos,
    input  logic [3:0]        v_sync_width,
    input  logic [RA_W-1:0]   v_adjust,
    output logic [PIX_W-1:0]  pix,
    output logic [3:0]        ra_lo,
    output logic [ADDR_W-1:0] ma,
    output logic              h_sync,
    output logic              h_active,
    output logic              v_sync,
    output logic              v_active,
    output logic              char_clk
);

    logic [PIX_W-1:0]  r_pix, w_pix_next;
    logic [H_W-1:0]    r_h, w_h_next, w_h_diff;
    logic [RA_W-1:0]   r_ra, w_ra_next;
    logic [V_W-1:0]    r_v, w_v_next, w_v_diff;
    logic [RA_W-1:0]   r_adj, w_adj_next;
    logic [ADDR_W-1:0] r_row_start, w_row_next;
    vphase_t           r_phase, w_phase_next;
    logic              w_char_end, w_line_end;
    logic              r_h_sync, r_h_active, r_v_sync, r_v_active, r_char_clk;
    logic              w_h_sync, w_h_active, w_v_sync, w_v_active, w_char_clk;

    always_comb begin
        w_pix_next   = r_pix + 3'd1;
        w_char_end   = (r_pix == 3'(PIX_PER_CHAR - 1));
        w_line_end   = w_char_end && (r_h == h_char_total);
        w_h_next     = r_h;
        w_ra_next    = r_ra;
        w_v_next     = r_v;
        w_adj_next   = r_adj;
        w_row_next   = r_row_start;
        w_phase_next = r_phase;

        if (w_char_end) begin
            w_h_next = w_line_end ? '0 : r_h + 8'd1;
        end

        if (w_line_end) begin
            w_ra_next = r_ra + 5'd1;
            case (r_phase)
                PH_DISPLAY: begin
                    if (r_ra == v_char_height) begin
                        w_ra_next  = '0;
                        w_row_next = r_row_start + ADDR_W'(h_char_displayed);
                        if (r_v == v_char_total) begin
                            if (v_adjust == '0) begin
                                w_v_next   = '0;
                                w_row_next = '0;
                            end else begin
                                w_phase_next = PH_ADJUST;
                                w_adj_next   = '0;
                            end
                        end else begin
                            w_v_next = r_v + 7'd1;
                        end
                    end
                end
                PH_ADJUST: begin
                    // >= so a v_adjust shrunk mid-phase still ends the frame
                    if ((r_adj + 5'd1) >= v_adjust) begin
                        w_phase_next = PH_DISPLAY;
                        w_adj_next   = '0;
                        w_ra_next    = '0;
                        w_v_next     = '0;
                        w_row_next   = '0;
                    end else begin
                        w_adj_next = r_adj + 5'd1;
                    end
                end
                default: w_phase_next = PH_DISPLAY;
            endcase
        end

        // Windows are derived from next-state counters so they move on the same edge
        w_h_diff   = w_h_next - h_sync_pos;
        w_v_diff   = w_v_next - v_sync_pos;
        w_h_active = (w_h_next < h_char_displayed);
        w_h_sync   = (w_h_diff < H_W'(h_sync_width));
        w_v_active = (w_phase_next == PH_DISPLAY) && (w_v_next < v_char_displayed);
        w_v_sync   = (w_phase_next == PH_DISPLAY) && (w_v_diff < V_W'(v_sync_width));
        w_char_clk = (w_pix_next < 3'(PIX_PER_CHAR / 2));
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            r_pix       <= '0;
            r_h         <= '0;
            r_ra        <= '0;
            r_v         <= '0;
            r_adj       <= '0;
            r_row_start <= '0;
            r_phase     <= PH_DISPLAY;
            r_h_sync    <= 1'b0;
            r_h_active  <= 1'b0;
            r_v_sync    <= 1'b0;
            r_v_active  <= 1'b0;
            r_char_clk  <= 1'b0;
        end else begin
            r_pix       <= w_pix_next;
            r_h         <= w_h_next;
            r_ra        <= w_ra_next;
            r_v         <= w_v_next;
            r_adj       <= w_adj_next;
            r_row_start <= w_row_next;
            r_phase     <= w_phase_next;
            r_h_sync    <= w_h_sync;
            r_h_active  <= w_h_active;
            r_v_sync    <= w_v_sync;
            r_v_active  <= w_v_active;
            r_char_clk  <= w_char_clk;
        end
    end

    assign pix      = r_pix;
    assign ra_lo    = r_ra[3:0];
    assign ma       = r_row_start + ADDR_W'(r_h);
    assign h_sync   = r_h_sync;
    assign h_active = r_h_active;
    assign v_sync   = r_v_sync;
    assign v_active = r_v_active;
    assign char_clk = r_char_clk;

endmodule
`default_nettype wire

// File: rtl/pet_video_crtc.sv
`default_nettype none
// ============================================================================
// Module      : pet_video_crtc
// Description : PET text-mode CRTC: timing core plus screen/glyph fetch
//               latches, address mux and serial pixel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module pet_video_crtc #(
    parameter int ADDR_W = 12
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic [7:0]        h_char_total,
    input  logic [7:0]        h_char_displayed,
    input  logic [7:0]        h_sync_pos,
    input  logic [3:0]        h_sync_width,
    input  logic [4:0]        v_char_height,
    input  logic [6:0]        v_char_total,
    input  logic [6:0]        v_char_displayed,
    input  logic [6:0]        v_sync_pos,
    input  logic [3:0]        v_sync_width,
    input  logic [4:0]        v_adjust,
    input  logic              video_ram_strobe,
    input  logic              video_rom_strobe,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              h_sync,
    output logic              h_active,
    output logic              v_sync,
    output logic              v_active,
    output logic              char_clk,
    output logic              video
);
    import pet_video_pkg::*;

    logic [PIX_W-1:0]                w_pix;
    logic [3:0]                      w_ra_lo;
    logic [pet_video_pkg::ADDR_W-1:0] w_ma;
    logic                            w_char_end;
    logic [ADDR_W-1:0]               r_addr;
    logic [7:0]                      r_char_code, r_glyph, r_shift, w_shift_next;
    logic                            r_hd, r_vd, w_hd_next, w_vd_next, r_video;

    crtc_timing u_timing (
        .pixel_clk        (pixel_clk),
        .reset            (reset),
        .h_char_total     (h_char_total),
        .h_char_displayed (h_char_displayed),
        .h_sync_pos       (h_sync_pos),
        .h_sync_width     (h_sync_width),
        .v_char_height    (v_char_height),
        .v_char_total     (v_char_total),
        .v_char_displayed (v_char_displayed),
        .v_sync_pos       (v_sync_pos),
        .v_sync_width     (v_sync_width),
        .v_adjust         (v_adjust),
        .pix              (w_pix),
        .ra_lo            (w_ra_lo),
        .ma               (w_ma),
        .h_sync           (h_sync),
        .h_active         (h_active),
        .v_sync           (v_sync),
        .v_active         (v_active),
        .char_clk         (char_clk)
    );

    // The shifter displays the previous cell's glyph, so the windows lag by one cell too
    always_comb begin
        w_char_end   = (w_pix == 3'(PIX_PER_CHAR - 1));
        w_shift_next = {r_shift[6:0], 1'b0};
        w_hd_next    = r_hd;
        w_vd_next    = r_vd;
        if (w_char_end) begin
            w_shift_next = r_glyph;
            w_hd_next    = h_active;
            w_vd_next    = v_active;
        end
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_char_code <= '0;
            r_glyph     <= '0;
            r_shift     <= '0;
            r_hd        <= 1'b0;
            r_vd        <= 1'b0;
            r_video     <= 1'b0;
        end else begin
            if (video_ram_strobe) begin
                r_addr      <= ADDR_W'(w_ma);
                r_char_code <= data_in;
            end else if (video_rom_strobe) begin
                r_addr  <= ADDR_W'({r_char_code, w_ra_lo});
                r_glyph <= data_in;
            end
            r_shift <= w_shift_next;
            r_hd    <= w_hd_next;
            r_vd    <= w_vd_next;
            r_video <= w_shift_next[7] & w_hd_next & w_vd_next;
        end
    end

    assign addr_out = r_addr;
    assign video    = r_video;

endmodule
`default_nettype wire

// File: tb/tb_pet_video_crtc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pet_video_crtc
// Description : Scoreboard bench for pet_video_crtc against a frame-position
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pet_video_crtc;

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  h_char_total, h_char_displayed, h_sync_pos;
    logic [3:0]  h_sync_width, v_sync_width;
    logic [4:0]  v_char_height, v_adjust;
    logic [6:0]  v_char_total, v_char_displayed, v_sync_pos;
    logic        video_ram_strobe = 1'b0, video_rom_strobe = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [11:0] addr_out;
    logic        h_sync, h_active, v_sync, v_active, char_clk, video;

    pet_video_crtc dut (
        .pixel_clk        (pixel_clk),
        .reset            (reset),
        .h_char_total     (h_char_total),
        .h_char_displayed (h_char_displayed),
        .h_sync_pos       (h_sync_pos),
        .h_sync_width     (h_sync_width),
        .v_char_height    (v_char_height),
        .v_char_total     (v_char_total),
        .v_char_displayed (v_char_displayed),
        .v_sync_pos       (v_sync_pos),
        .v_sync_width     (v_sync_width),
        .v_adjust         (v_adjust),
        .video_ram_strobe (video_ram_strobe),
        .video_rom_strobe (video_rom_strobe),
        .data_in          (data_in),
        .addr_out         (addr_out),
        .h_sync           (h_sync),
        .h_active         (h_active),
        .v_sync           (v_sync),
        .v_active         (v_active),
        .char_clk         (char_clk),
        .video            (video)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        longint      e;
        logic [17:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    int c_htot, c_hdisp, c_hspos, c_hsw, c_vh, c_vtot, c_vdisp, c_vspos, c_vsw, c_vadj;

    logic [7:0]  m_glyph, m_code, m_disp;
    logic [11:0] m_addr;
    logic        m_dact;

    function automatic logic [17:0] outs();
        return {h_sync, h_active, v_sync, v_active, char_clk, video, addr_out};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got hs,ha,vs,va,cc,vid=%b addr=%03h expected hs,ha,vs,va,cc,vid=%b addr=%03h",
                      name, act[17:12], act[11:0], exp[17:12], exp[11:0]);
    endtask

    // Position in the frame after n clocks since reset release
    function automatic void model_pos(input longint n, output int h, output int row,
                                      output int ra, output bit adj);
        longint line_len, row_lines, frame_lines, li;
        line_len    = longint'(c_htot + 1) * 8;
        row_lines   = longint'(c_vh + 1) * (c_vtot + 1);
        frame_lines = row_lines + c_vadj;
        h   = int'((n % line_len) / 8);
        li  = (n / line_len) % frame_lines;
        adj = (li >= row_lines);
        row = adj ? c_vtot + 1 : int'(li / (c_vh + 1));
        ra  = adj ? int'(li - row_lines) : int'(li % (c_vh + 1));
    endfunction

    function automatic bit model_active(input longint n);
        int h, row, ra;
        bit adj;
        model_pos(n, h, row, ra, adj);
        return (h < c_hdisp) && !adj && (row < c_vdisp);
    endfunction

    task automatic set_cfg(input int htot, hdisp, hspos, hsw, vh, vtot, vdisp, vspos, vsw, vadj);
        c_htot = htot; c_hdisp = hdisp; c_hspos = hspos; c_hsw = hsw; c_vh = vh;
        c_vtot = vtot; c_vdisp = vdisp; c_vspos = vspos; c_vsw = vsw; c_vadj = vadj;
        h_char_total = 8'(htot); h_char_displayed = 8'(hdisp); h_sync_pos = 8'(hspos);
        h_sync_width = 4'(hsw); v_char_height = 5'(vh); v_char_total = 7'(vtot);
        v_char_displayed = 7'(vdisp); v_sync_pos = 7'(vspos); v_sync_width = 4'(vsw);
        v_adjust = 5'(vadj);
    endtask

    task automatic model_clear();
        m_glyph = 8'h00; m_code = 8'h00; m_disp = 8'h00; m_addr = 12'h000; m_dact = 1'b0;
    endtask

    task automatic run_cfg(input int cycles, input int pulse_at, input bit directed);
        logic        ram, rom;
        logic [7:0]  d;
        logic        hs, ha, vs, va, cc, vid;
        longint      n, e;
        int          h, row, ra, pix;
        bit          adj;
        reset = 1'b0;
        video_ram_strobe = 1'b0;
        video_rom_strobe = 1'b0;
        repeat (3) @(negedge pixel_clk);
        check("reset_state", outs(), 18'd0);
        reset = 1'b1;
        model_clear();
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            if (k == pulse_at) begin
                reset = 1'b0;
                #1;
                check("async_reset", outs(), 18'd0);
                reset = 1'b1;
                model_clear();
                n = 0;
            end
            pix = int'(n % 8);
            if (directed) begin
                ram = (pix == 2);
                rom = (pix == 5);
                d   = ram ? 8'h01 : (rom ? 8'hA5 : 8'h00);
            end else begin
                ram = ($urandom_range(0, 7) == 0);
                rom = ($urandom_range(0, 5) == 0);
                d   = 8'($urandom);
            end
            video_ram_strobe = ram;
            video_rom_strobe = rom;
            data_in          = d;

            e = n + 1;
            if (e % 8 == 0) begin
                m_disp = m_glyph;
                m_dact = model_active(e - 1);
            end
            model_pos(e - 1, h, row, ra, adj);
            if (ram) begin
                m_addr = 12'((row * c_hdisp + h) % 4096);
                m_code = d;
            end else if (rom) begin
                m_addr = {m_code, 4'(ra)};
                m_glyph = d;
            end
            model_pos(e, h, row, ra, adj);
            ha  = (h < c_hdisp);
            hs  = (((h - c_hspos) & 255) < c_hsw);
            va  = !adj && (row < c_vdisp);
            vs  = !adj && (((row - c_vspos) & 127) < c_vsw);
            cc  = ((e % 8) < 4);
            vid = m_disp[3'(7 - e % 8)] & m_dact;
            sb.push_back('{e, {hs, ha, vs, va, cc, vid, m_addr}});
            @(negedge pixel_clk);
            n = e;
        end
        video_ram_strobe = 1'b0;
        video_rom_strobe = 1'b0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge pixel_clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check($sformatf("outputs@edge%0d", x.e), outs(), x.v);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_total);
        $fatal(1);
    end

    initial begin : stim
        // Minimal timing, directed fetches, reset pulse mid-frame
        set_cfg(1, 1, 1, 1, 7, 1, 1, 1, 1, 4);
        run_cfg(1400, 450, 1'b1);
        // 40x25 layout
        set_cfg(63, 40, 45, 6, 0, 24, 25, 27, 3, 2);
        run_cfg(7000, -1, 1'b0);
        // Refresh address wrap and sync windows wrapping modulo 256/128
        set_cfg(255, 255, 250, 15, 0, 20, 18, 126, 5, 3);
        run_cfg(36000, -1, 1'b0);
        // Zero sync widths
        set_cfg(9, 6, 7, 0, 2, 4, 3, 2, 0, 0);
        run_cfg(3000, -1, 1'b0);
        // Random small timing
        for (int i = 0; i < 2; i++) begin
            int ht;
            ht = int'($urandom_range(3, 20));
            set_cfg(ht, int'($urandom_range(0, ht + 2)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                    int'($urandom_range(1, 6)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 5)));
            run_cfg(1500, 700, 1'b0);
        end
        @(negedge pixel_clk);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drained: %0d entries left, required 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
